// File: rtl/maze_grid_mem.sv
// Maze grid store: W x H cells, one bit per cell (1 = wall, 0 = free).
// The write side serves the loader/editor. The read side serves the path-search
// controller with a registered single-cell or 4-neighbour read. A hardware
// clear/fill sweep writes one full row per cycle while busy is high.
module maze_grid_mem #(
  parameter int    W         = 16,
  parameter int    H         = 16,
  parameter int    XW        = 5,
  parameter int    YW        = 5,
  parameter string INIT_FILE = "maze_map.txt"
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic          rd,
  input  logic          nbr,
  input  logic          wr,
  input  logic          d_in,
  input  logic          clr,
  input  logic          clr_val,
  output logic          d_out,
  output logic [3:0]    nbr_out,
  output logic          oob,
  output logic          rd_valid,
  output logic          busy
);

  localparam int XIW = $clog2(W);
  localparam int YIW = $clog2(H);

  // Coordinates carry one extra bit so x+1 and y+1 never wrap back into the
  // grid, and x-1 / y-1 from 0 become all-ones, which is always out of range.
  localparam logic [XW:0]   W_X      = (XW+1)'(W);
  localparam logic [YW:0]   H_Y      = (YW+1)'(H);
  localparam logic [XW:0]   X_ONE    = {{XW{1'b0}}, 1'b1};
  localparam logic [YW:0]   Y_ONE    = {{YW{1'b0}}, 1'b1};
  localparam logic [YW-1:0] ROW_ONE  = {{(YW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] LAST_ROW = YW'(H - 1);

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_e;

  state_e        state_q, state_d;
  logic [YW-1:0] row_q, row_d;
  logic          fill_q, fill_d;

  logic [W-1:0]  mem_q [H];

  logic          d_out_q;
  logic [3:0]    nbr_out_q;
  logic          oob_q;
  logic          rd_valid_q;

  logic [XW:0]   xc, xe, xw;
  logic [YW:0]   yc, yn, ys;
  logic          in_bounds;
  logic          centre_val;
  logic [3:0]    nbr_val;
  logic          busy_w;
  logic          clr_acc;
  logic          rd_acc;
  logic          wr_acc;

  // Cell lookup with the grid edge treated as wall.
  function automatic logic cell_at(input logic [XW:0] cx, input logic [YW:0] cy);
    logic v;
    v = 1'b1;
    if ((cx < W_X) && (cy < H_Y)) begin
      v = mem_q[cy[YIW-1:0]][cx[XIW-1:0]];
    end
    return v;
  endfunction

  assign xc = {1'b0, x};
  assign yc = {1'b0, y};
  assign xe = xc + X_ONE;
  assign xw = xc - X_ONE;
  assign yn = yc - Y_ONE;
  assign ys = yc + Y_ONE;

  assign busy_w    = (state_q == S_SWEEP);
  assign in_bounds = (xc < W_X) && (yc < H_Y);

  // A clear wins over a same-cycle read or write; nothing is accepted while sweeping.
  assign clr_acc = clr & ~busy_w;
  assign rd_acc  = rd  & ~busy_w & ~clr;
  assign wr_acc  = wr  & ~busy_w & ~clr & in_bounds;

  // Read data from current (pre-write) contents; an out-of-grid centre reads as all walls.
  always_comb begin
    centre_val = cell_at(xc, yc);
    nbr_val    = 4'b1111;
    if (in_bounds) begin
      nbr_val = {cell_at(xc, yn), cell_at(xe, yc), cell_at(xc, ys), cell_at(xw, yc)};
    end
  end

  // Sweep FSM next state: one row per busy cycle, back to idle after the last row.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    fill_d  = fill_q;
    case (state_q)
      S_IDLE: begin
        if (clr_acc) begin
          state_d = S_SWEEP;
          row_d   = '0;
          fill_d  = clr_val;
        end
      end
      S_SWEEP: begin
        if (row_q == LAST_ROW) begin
          state_d = S_IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + ROW_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        row_d   = '0;
      end
    endcase
  end

  // Sweep FSM state register; reset aborts a sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      fill_q  <= fill_d;
    end
  end

  // Cell storage: sweep row fill or a single accepted write (rows already swept survive a reset).
  always_ff @(posedge clk) begin
    if (busy_w) begin
      mem_q[row_q[YIW-1:0]] <= {W{fill_q}};
    end else if (wr_acc) begin
      mem_q[y[YIW-1:0]][x[XIW-1:0]] <= d_in;
    end
  end

  // Registered read port with one-cycle valid strobe; outputs hold between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_q    <= 1'b0;
      nbr_out_q  <= 4'b0000;
      oob_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        d_out_q <= centre_val;
        oob_q   <= ~in_bounds;
        if (nbr) begin
          nbr_out_q <= nbr_val;
        end
      end
    end
  end

  assign d_out    = d_out_q;
  assign nbr_out  = nbr_out_q;
  assign oob      = oob_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_w;

endmodule

// File: tb/tb_maze_grid_mem.sv
// Scoreboard bench for maze_grid_mem: directed reads push expected responses,
// an independent monitor pops and compares on every rd_valid.
module tb_maze_grid_mem;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int XW = 5;
  localparam int YW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          rd, nbr, wr, d_in, clr, clr_val;
  logic          d_out;
  logic [3:0]    nbr_out;
  logic          oob, rd_valid, busy;

  maze_grid_mem #(.W(W), .H(H), .XW(XW), .YW(YW), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .rd(rd), .nbr(nbr), .wr(wr),
    .d_in(d_in), .clr(clr), .clr_val(clr_val), .d_out(d_out),
    .nbr_out(nbr_out), .oob(oob), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       d;
    logic [3:0] n;
    logic       o;
    string      tag;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           errors = 0;
  int           checks = 0;
  logic [3:0]   last_nbr;
  logic [W-1:0] img [H];
  logic [W-1:0] pre [H];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd_valid: got d=%b n=%b o=%b with no read outstanding",
                   d_out, nbr_out, oob);
        end else begin
          mon_e = sb.pop_front();
          if ({d_out, nbr_out, oob} !== {mon_e.d, mon_e.n, mon_e.o}) begin
            errors++;
            $display("FAIL %s: got d=%b n=%b o=%b, expected d=%b n=%b o=%b",
                     mon_e.tag, d_out, nbr_out, oob, mon_e.d, mon_e.n, mon_e.o);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One cycle of stimulus; a read pushes its expected response.
  task automatic drive(input int cx, input int cy, input logic rdv, input logic nb,
                       input logic wrv, input logic dv, input logic ed,
                       input logic [3:0] en, input logic eo, input string tag);
    exp_t e;
    x    = cx[XW-1:0];
    y    = cy[YW-1:0];
    rd   = rdv;
    nbr  = nb;
    wr   = wrv;
    d_in = dv;
    clr  = 1'b0;
    if (rdv) begin
      e.d   = ed;
      e.o   = eo;
      e.tag = tag;
      if (nb) begin
        e.n      = en;
        last_nbr = en;
      end else begin
        e.n = last_nbr;
      end
      sb.push_back(e);
    end
    if (wrv && cx < W && cy < H) img[cy][cx] = dv;
    @(negedge clk);
  endtask

  task automatic idle();
    rd  = 1'b0;
    wr  = 1'b0;
    nbr = 1'b0;
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic readback(input string tag);
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        drive(xx, yy, 1'b1, 1'b0, 1'b0, 1'b0, img[yy][xx], 4'b0000, 1'b0,
              $sformatf("%s_%0d_%0d", tag, xx, yy));
      end
    end
    idle();
  endtask

  // Clear sweep; with mid set, a rd+wr and a second clr are issued while busy.
  task automatic do_clear(input logic val, input bit mid);
    int cnt;
    cnt     = 0;
    rd      = 1'b0;
    wr      = 1'b0;
    nbr     = 1'b0;
    clr     = 1'b1;
    clr_val = val;
    @(negedge clk);
    clr     = 1'b0;
    clr_val = ~val;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      rd  = 1'b0;
      wr  = 1'b0;
      clr = 1'b0;
      if (mid && cnt == 10) begin
        rd   = 1'b1;
        wr   = 1'b1;
        x    = 5'd2;
        y    = 5'd2;
        d_in = ~val;
      end
      if (mid && cnt == 12) clr = 1'b1;
      @(negedge clk);
    end
    rd  = 1'b0;
    wr  = 1'b0;
    clr = 1'b0;
    chk($sformatf("busy_cycles_fill%0b", val), cnt, H);
    for (int r = 0; r < H; r++) img[r] = {W{val}};
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; nbr = 1'b0; d_in = 1'b0;
    clr = 1'b0; clr_val = 1'b0; x = '0; y = '0; last_nbr = 4'b0000;
    for (int r = 0; r < H; r++) pre[r] = '0;
    pre[0]  = 16'h8001;
    pre[1]  = 16'h000A;
    pre[2]  = 16'h0008;
    pre[7]  = 16'h0080;
    pre[14] = 16'h0400;

    repeat (2) @(negedge clk);
    chk("reset_d_out", d_out, 1'b0);
    chk("reset_nbr_out", nbr_out, 4'b0000);
    chk("reset_oob", oob, 1'b0);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;

    // Known contents, then the maze image written cell by cell.
    do_clear(1'b0, 1'b0);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        drive(xx, yy, 1'b0, 1'b0, 1'b1, pre[yy][xx], 1'b0, 4'b0000, 1'b0, "");
    idle();

    // Single read with strobe timing.
    drive(3, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, "rd_3_2");
    chk("rd_valid_strobe", rd_valid, 1'b1);
    idle();
    chk("rd_valid_drop", rd_valid, 1'b0);

    // Out-of-bounds read, dropped out-of-bounds write, full image readback.
    drive(16, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, "rd_oob_16_0");
    drive(16, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "");
    idle();
    readback("pre");

    // Neighbour reads on the image.
    drive(3, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, "nbr_3_2");
    drive(1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, "nbr_1_0");
    drive(15, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, "nbr_15_0");
    drive(16, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, "nbr_oob_16_2");
    idle();

    // Corners after clearing to free.
    do_clear(1'b0, 1'b0);
    drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, "nbr_corner_0_0");
    drive(15, 15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, "nbr_corner_15_15");
    idle();

    // Same-cycle read and write return the old value.
    drive(5, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, "rdw_old_5_5");
    drive(5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, "rdw_new_5_5");
    drive(5, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, "rdw_nbr_old_5_5");
    drive(5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "rdw_cleared_5_5");
    idle();

    // Fill with walls while poking the ports mid-sweep.
    do_clear(1'b1, 1'b1);
    readback("fill1");
    drive(20, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, "nbr_oob_20_3");
    idle();

    // Reset on busy cycle 5 aborts the sweep after row 4.
    clr     = 1'b1;
    clr_val = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) begin
        chk("busy_before_abort", busy, 1'b1);
        rst = 1'b1;
      end
      @(negedge clk);
    end
    chk("abort_busy", busy, 1'b0);
    chk("abort_d_out", d_out, 1'b0);
    chk("abort_nbr_out", nbr_out, 4'b0000);
    chk("abort_oob", oob, 1'b0);
    chk("abort_rd_valid", rd_valid, 1'b0);
    rst      = 1'b0;
    last_nbr = 4'b0000;
    for (int r = 0; r < 5; r++) img[r] = '0;
    idle();
    readback("abort");

    repeat (3) idle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
